fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch and sequencing stage that sits directly upstream of the CPU control unit.
- Holds the program counter and issues requests to instruction memory over a req/ack handshake.
- Latches each returned word into an instruction register and presents its 4-bit opcode and operand to the control unit.
- On commit, takes the control unit's jmp_sel back to choose between PC+1 and the branch target.

Parameters:
- PC_W, 8, program counter / instruction address width; must be <= DATA_W.
- DATA_W, 8, operand field width (immediate or jump target).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- imem_req  output  1  fetch request to instruction memory
- imem_addr  output  PC_W  fetch address (equals pc)
- imem_ack  input  1  memory returns imem_instr this cycle
- imem_instr  input  4+DATA_W  instruction word: [DATA_W+3:DATA_W] opcode, [DATA_W-1:0] operand
- opcode  output  4  latched opcode, drives control unit
- operand  output  DATA_W  latched operand (immediate / jump target)
- instr_valid  output  1  opcode/operand valid; instruction executing
- jmp_sel  input  1  from control unit: take jump on commit
- ex_stall  input  1  downstream not ready; hold current instruction
- halt  input  1  stop fetching after the current instruction commits
- pc  output  PC_W  current program counter
- halted  output  1  fetch unit stopped

Behaviour:
- States: RESET_IDLE, REQ, EXEC, HALTED. Encoding is free.
- Reset (asynchronous, while rst=1):
  - state=RESET_IDLE, pc=RESET_PC.
  - opcode=0, operand=0, instr_valid=0, imem_req=0, halted=0.
  - imem_addr follows pc, i.e. RESET_PC.
  - Reset asserted mid-handshake abandons the request; a late imem_ack is ignored.
- RESET_IDLE: unconditionally moves to REQ on the first clock edge after rst deasserts. imem_req=0.
- REQ:
  - imem_req=1 and imem_addr=pc, held stable until ack.
  - On a cycle with imem_ack=1: IR <= imem_instr (opcode/operand update on that edge) and state goes to EXEC.
  - If imem_ack=0, stay in REQ with unbounded wait.
  - imem_ack in any state other than REQ is ignored.
- EXEC:
  - imem_req=0, instr_valid=1. opcode/operand are held constant.
  - jmp_sel is combinational from the control unit and is sampled only on the commit edge.
  - ex_stall=1: remain in EXEC; pc, IR and instr_valid are unchanged.
  - ex_stall=0 (commit edge):
    - pc <= jmp_sel ? operand[PC_W-1:0] : pc+1, modulo 2^PC_W (all-ones+1 wraps to 0).
    - Next state is HALTED if halt=1, else REQ.
  - halt is sampled only on the commit edge. halt during REQ or a stalled EXEC does not abort the instruction.
- HALTED:
  - halted=1, imem_req=0, instr_valid=0.
  - pc holds the post-commit value; opcode/operand hold their last values.
  - Exit only via rst.
- Throughput: minimum 2 cycles per instruction (REQ with same-cycle ack, then EXEC with no stall).
- instr_valid is 0 in every state except EXEC.
- Simultaneous ex_stall=1 and halt=1: the stall wins, and halt is re-evaluated at the eventual commit.
- Simultaneous jmp_sel=1 and halt=1 at commit: the jump target is loaded into pc, then the unit halts.
- Widths: operand truncates to its low PC_W bits for the jump target. The pc+1 carry is discarded.

Test Plan:
- Reset release with RESET_PC=0 and memory acking same cycle: imem_addr sequence is 0,1,2,3; instr_valid pulses one cycle every 2 cycles; opcode/operand match the words at those addresses.
- Memory ack delayed 3 cycles at addr 5: imem_req stays 1 with imem_addr=5 for 4 cycles; instr_valid stays 0 until the cycle after ack; pc advances to 6 after commit.
- Word opcode=4'h8, operand=8'h20 at pc=0x10 with jmp_sel=1: next imem_addr=0x20. The same word with jmp_sel=0 gives next imem_addr=0x11.
- pc=0xFF with no jump: next pc=0x00 (wrap). ex_stall=1 for 2 cycles in EXEC: instr_valid held 3 cycles, pc unchanged until ex_stall drops.
- halt=1 on the commit edge at pc=0x07 with jmp_sel=0: halted=1, pc=0x08, imem_req stays 0 forever; a late imem_ack pulse changes nothing.
- rst asserted while in REQ with imem_req=1: outputs return to reset values immediately (asynchronously, not waiting for clk). After release, fetch restarts at RESET_PC; an ack arriving during reset is ignored.

Source files
------------

// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
//   Groups the signals between the fetch unit, the instruction memory and the
//   CPU control unit.
//
//   Signals:
//     imem_req     fetch request to instruction memory
//     imem_addr    fetch address (always equals pc)
//     imem_ack     memory returns imem_instr this cycle
//     imem_instr   instruction word {opcode[3:0], operand[DATA_W-1:0]}
//     opcode       latched opcode presented to the control unit
//     operand      latched operand (immediate / jump target)
//     instr_valid  opcode/operand valid, instruction executing
//     jmp_sel      control unit: take the jump on commit
//     ex_stall     control unit: hold the current instruction
//     halt         stop fetching after the current instruction commits
//     pc           current program counter
//     halted       fetch unit has stopped
//
//   Modports:
//     master  fetch unit side
//     slave   memory / control unit side
// -----------------------------------------------------------------------------
interface fetch_unit_if #(
  parameter int PC_W   = 8,
  parameter int DATA_W = 8
);
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_ack;
  logic [DATA_W+3:0] imem_instr;
  logic [3:0]        opcode;
  logic [DATA_W-1:0] operand;
  logic              instr_valid;
  logic              jmp_sel;
  logic              ex_stall;
  logic              halt;
  logic [PC_W-1:0]   pc;
  logic              halted;

  modport master (
    output imem_req, imem_addr, opcode, operand, instr_valid, pc, halted,
    input  imem_ack, imem_instr, jmp_sel, ex_stall, halt
  );

  modport slave (
    input  imem_req, imem_addr, opcode, operand, instr_valid, pc, halted,
    output imem_ack, imem_instr, jmp_sel, ex_stall, halt
  );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch and sequencing stage in front of the CPU control unit.
//   Holds the program counter, fetches one word at a time over a req/ack
//   handshake, latches it into the instruction register and presents the
//   opcode/operand to the control unit.  When the control unit commits
//   (ex_stall low) the pc advances to pc+1 or to the jump target selected by
//   jmp_sel, and the unit either fetches again or halts.
//
//   Parameters:
//     PC_W      program counter / instruction address width (must be <= DATA_W)
//     DATA_W    operand field width
//     RESET_PC  pc value loaded on reset
//
//   Ports:
//     clk   system clock, rising edge
//     rst   asynchronous, active-high reset
//     bus   fetch_unit_if.master: memory handshake, IR outputs, control inputs
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int PC_W     = 8,
  parameter int DATA_W   = 8,
  parameter int RESET_PC = 0
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    RESET_IDLE = 2'd0,
    REQ        = 2'd1,
    EXEC       = 2'd2,
    HALTED     = 2'd3
  } state_t;

  state_t            r_state;
  logic [PC_W-1:0]   r_pc;
  logic [3:0]        r_opcode;
  logic [DATA_W-1:0] r_operand;
  logic              r_req;
  logic              r_valid;
  logic              r_halted;

  logic [PC_W-1:0]   w_pc_inc;
  logic [PC_W-1:0]   w_jmp_tgt;
  logic [PC_W-1:0]   w_pc_next;

  // pc+1 wraps naturally at PC_W bits; the jump target is the low PC_W bits
  // of the latched operand.
  assign w_pc_inc  = r_pc + PC_W'(1);
  assign w_jmp_tgt = r_operand[PC_W-1:0];
  assign w_pc_next = bus.jmp_sel ? w_jmp_tgt : w_pc_inc;

  // Single-process FSM.  imem_req, instr_valid and halted are registered and
  // set on the edge that enters the state they belong to, so every output is
  // glitch-free and consistent with r_state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= RESET_IDLE;
      r_pc      <= PC_W'(RESET_PC);
      r_opcode  <= '0;
      r_operand <= '0;
      r_req     <= 1'b0;
      r_valid   <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      case (r_state)
        RESET_IDLE: begin
          r_state <= REQ;
          r_req   <= 1'b1;
        end

        // Wait (unbounded) for the memory; address is r_pc and stays put.
        REQ: begin
          if (bus.imem_ack) begin
            r_opcode  <= bus.imem_instr[DATA_W+3:DATA_W];
            r_operand <= bus.imem_instr[DATA_W-1:0];
            r_req     <= 1'b0;
            r_valid   <= 1'b1;
            r_state   <= EXEC;
          end
        end

        // jmp_sel and halt only matter on the commit edge; a stall holds
        // everything, including a pending halt request.
        EXEC: begin
          if (!bus.ex_stall) begin
            r_pc    <= w_pc_next;
            r_valid <= 1'b0;
            if (bus.halt) begin
              r_halted <= 1'b1;
              r_state  <= HALTED;
            end else begin
              r_req   <= 1'b1;
              r_state <= REQ;
            end
          end
        end

        // Terminal until reset; late acks and control inputs are ignored.
        HALTED: begin
          r_state <= HALTED;
        end

        default: begin
          r_state <= RESET_IDLE;
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req    = r_req;
  assign bus.imem_addr   = r_pc;
  assign bus.pc          = r_pc;
  assign bus.opcode      = r_opcode;
  assign bus.operand     = r_operand;
  assign bus.instr_valid = r_valid;
  assign bus.halted      = r_halted;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  logic clk;
  logic rst;

  fetch_unit_if #(.PC_W(8), .DATA_W(8)) bus ();

  fetch_unit #(.PC_W(8), .DATA_W(8), .RESET_PC(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] mem [256];
  logic [11:0] sb_q [$];
  logic [7:0]  exp_pc;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_req"},     bus.imem_req,    0);
    check_val({tag, "_valid"},   bus.instr_valid, 0);
    check_val({tag, "_halted"},  bus.halted,      0);
    check_val({tag, "_opcode"},  bus.opcode,      0);
    check_val({tag, "_operand"}, bus.operand,     0);
    check_val({tag, "_pc"},      bus.pc,          0);
    check_val({tag, "_addr"},    bus.imem_addr,   0);
  endtask

  // One full instruction: wait for the request, ack after dly cycles, stall
  // for stall cycles (halt held high during the stall when hlt is set), then
  // commit with jmp/hlt.  Called on a negedge, returns on a negedge.
  task automatic do_instr(input int dly, input int stall, input bit jmp, input bit hlt);
    int n;
    logic [11:0] w;
    logic [11:0] exp_w;
    n = 0;
    while (!bus.imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val("req_seen", bus.imem_req, 1);
    check_val("req_addr", bus.imem_addr, exp_pc);
    for (int i = 0; i < dly; i++) begin
      bus.imem_ack = 1'b0;
      @(negedge clk);
      check_val("wait_req",   bus.imem_req,    1);
      check_val("wait_addr",  bus.imem_addr,   exp_pc);
      check_val("wait_valid", bus.instr_valid, 0);
    end
    w = mem[exp_pc];
    bus.imem_instr = w;
    bus.imem_ack   = 1'b1;
    sb_q.push_back(w);
    @(negedge clk);
    bus.imem_ack   = 1'b0;
    bus.imem_instr = 12'h000;
    exp_w = sb_q.pop_front();
    check_val("exec_valid",   bus.instr_valid, 1);
    check_val("exec_req",     bus.imem_req,    0);
    check_val("exec_opcode",  bus.opcode,      exp_w[11:8]);
    check_val("exec_operand", bus.operand,     exp_w[7:0]);
    for (int i = 0; i < stall; i++) begin
      bus.ex_stall = 1'b1;
      bus.jmp_sel  = jmp;
      bus.halt     = hlt;
      @(negedge clk);
      check_val("stall_valid",  bus.instr_valid, 1);
      check_val("stall_pc",     bus.pc,          exp_pc);
      check_val("stall_opcode", bus.opcode,      exp_w[11:8]);
      check_val("stall_halted", bus.halted,      0);
    end
    bus.ex_stall = 1'b0;
    bus.jmp_sel  = jmp;
    bus.halt     = hlt;
    @(negedge clk);
    bus.jmp_sel = 1'b0;
    bus.halt    = 1'b0;
    exp_pc = jmp ? exp_w[7:0] : exp_pc + 8'd1;
    check_val("commit_pc",     bus.pc,          exp_pc);
    check_val("commit_valid",  bus.instr_valid, 0);
    check_val("commit_halted", bus.halted,      hlt);
    check_val("commit_req",    bus.imem_req,    !hlt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {i[3:0] ^ 4'hA, 8'(i * 7 + 3)};
    mem[0]   = 12'h307;
    mem[6]   = 12'h210;
    mem[16]  = 12'h820;
    mem[17]  = 12'h9FF;
    mem[32]  = 12'h510;
    mem[255] = 12'hC42;

    rst = 1'b0;
    bus.imem_ack   = 1'b0;
    bus.imem_instr = 12'h000;
    bus.jmp_sel    = 1'b0;
    bus.ex_stall   = 1'b0;
    bus.halt       = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    exp_pc = 8'h00;

    // sequential fetch, same-cycle ack
    do_instr(0, 0, 0, 0);
    do_instr(0, 0, 0, 0);
    do_instr(0, 0, 0, 0);
    do_instr(0, 0, 0, 0);
    do_instr(0, 0, 0, 0);
    // delayed ack at addr 5
    do_instr(3, 0, 0, 0);
    // jumps: 6 -> 0x10 -> 0x20 -> 0x10, then fall through to 0x11
    do_instr(0, 0, 1, 0);
    do_instr(0, 0, 1, 0);
    do_instr(0, 0, 1, 0);
    do_instr(0, 0, 0, 0);
    // 0x11 -> 0xFF, then wrap with a 2-cycle stall
    do_instr(0, 0, 1, 0);
    do_instr(0, 2, 0, 0);
    // 0x00 jumps to 0x07
    do_instr(1, 0, 1, 0);
    // halt held during a stall, then committed at 0x07
    do_instr(0, 1, 0, 1);

    for (int i = 0; i < 5; i++) begin
      bus.imem_ack   = (i == 1);
      bus.imem_instr = 12'hFFF;
      @(negedge clk);
      check_val("halt_halted", bus.halted,      1);
      check_val("halt_req",    bus.imem_req,    0);
      check_val("halt_pc",     bus.pc,          8'h08);
      check_val("halt_valid",  bus.instr_valid, 0);
      check_val("halt_opcode", bus.opcode,      mem[7][11:8]);
    end
    bus.imem_ack = 1'b0;

    // asynchronous reset out of HALTED
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_halted");
    @(negedge clk);
    rst = 1'b0;
    exp_pc = 8'h00;
    @(negedge clk);
    check_val("rerun_req",  bus.imem_req,  1);
    check_val("rerun_addr", bus.imem_addr, 0);

    // asynchronous reset in REQ, with an ack arriving during reset
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_req");
    bus.imem_ack   = 1'b1;
    bus.imem_instr = 12'hABC;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst_ack");
    bus.imem_ack   = 1'b0;
    bus.imem_instr = 12'h000;
    rst = 1'b0;
    do_instr(0, 0, 0, 0);
    do_instr(2, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
